bank_wait_ctrl: RTL and testbench

//  Parametrised chipset bank mapper and wait-state generator for the Mini8086 board. It maps the
//  80000-BFFFF region as NUM_WINDOWS equal windows, each pointed at a programmable physical bank
//  by an I/O register. It also stretches CPU bus cycles by a programmable number of clk cycles.

---
 rtl/bank_wait_ctrl.sv | 169 ++++++++++++++++
 tb/tb_bank_wait_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bank_wait_ctrl.sv
// Bank mapper and wait-state generator for the Mini8086 chipset.
// Maps 80000-BFFFF as NUM_WINDOWS windows onto programmable physical banks,
// provides an 8-port I/O register block for the bank and wait-count registers,
// and stretches CPU bus cycles by a programmable number of clocks via READY.
module bank_wait_ctrl #(
    parameter int         NUM_WINDOWS = 4,
    parameter int         BANK_BITS   = 5,
    parameter int         WAIT_BITS   = 3,
    parameter logic [9:0] IO_BASE     = 10'h030
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic [19:0]          ADDR,
    input  logic                 M_IO,
    input  logic                 RD,
    input  logic                 WR,
    input  logic [7:0]           DATA_IN,
    output logic [7:0]           DATA_OUT,
    output logic                 DATA_OE,
    input  logic                 RDY_EXT,
    output logic                 win_hit,
    output logic [BANK_BITS-1:0] bank_sel,
    output logic                 READY
);

    // Window index is the top address bits inside the 256KB region.
    localparam int WIN_SHIFT = 2 - $clog2(NUM_WINDOWS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] CTRL_PORT = 3'd7;

    logic [BANK_BITS-1:0] bank_q [NUM_WINDOWS];
    logic [7:0]           ctrl_q;
    logic                 rd_q, wr_q;
    logic [1:0]           state_q, state_d;
    logic [WAIT_BITS-1:0] cnt_q, cnt_d;
    logic                 ready_q, ready_d;

    logic [2:0]           port;
    logic                 in_block;
    logic                 wr_commit;
    logic                 start;
    logic                 strobes_idle;
    logic [1:0]           win_idx;
    logic [WAIT_BITS-1:0] wait_n;
    logic                 unused_addr;

    assign port         = ADDR[2:0];
    assign in_block     = ~M_IO & (ADDR[9:3] == IO_BASE[9:3]);
    assign strobes_idle = RD & WR;
    // A write commits on the rising edge of WR, using the address/data of that cycle.
    assign wr_commit    = ~wr_q & WR & in_block;
    assign start        = rd_q & wr_q & ~strobes_idle;
    assign unused_addr  = ^ADDR[15:10];

    // Window mapping: which bank the current memory cycle lands in.
    assign win_hit  = M_IO & (~RD | ~WR) & (ADDR[19:18] == 2'b10);
    assign win_idx  = ADDR[17:16] >> WIN_SHIFT;
    assign bank_sel = win_hit ? bank_q[win_idx] : '0;

    // Register read-back; the bus sees 8'hFF whenever we are not driving.
    assign DATA_OE = in_block & ~RD;
    always_comb begin
        // NOTE: default assignment first so every path drives the output and no latch is inferred.
        DATA_OUT = 8'hFF;
        if (DATA_OE) begin
            if (port == CTRL_PORT) begin
                DATA_OUT = ctrl_q;
            end else if (port < 3'(NUM_WINDOWS)) begin
                DATA_OUT = 8'(bank_q[port[1:0]]);
            end
        end
    end

    // Wait count selected for the cycle now starting.
    always_comb begin
        wait_n = '0;
        if (win_hit) begin
            wait_n = ctrl_q[WAIT_BITS-1:0];
        end else if (~M_IO) begin
            wait_n = ctrl_q[WAIT_BITS+3:4];
        end
    end

    // Strobe history and the bank/control register file.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (RESET) begin
            rd_q   <= 1'b1;
            wr_q   <= 1'b1;
            ctrl_q <= 8'h00;
            // NOTE: the bank array is reset element by element because the identity map is visible state.
            for (int i = 0; i < NUM_WINDOWS; i++) begin
                bank_q[i] <= BANK_BITS'(i);
            end
        end else begin
            rd_q <= RD;
            wr_q <= WR;
            if (wr_commit) begin
                if (port == CTRL_PORT) begin
                    ctrl_q <= DATA_IN;
                end else if (port < 3'(NUM_WINDOWS)) begin
                    bank_q[port[1:0]] <= DATA_IN[BANK_BITS-1:0];
                end
            end
        end
    end

    // Wait-state FSM next-state logic; READY defaults to following RDY_EXT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = RDY_EXT;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (wait_n != '0) begin
                        state_d = S_WAIT;
                        cnt_d   = wait_n;
                        ready_d = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT: begin
                if (strobes_idle) begin
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == WAIT_BITS'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        ready_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                if (strobes_idle) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    // Wait-state FSM registers; reset wins over any simultaneous start.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign READY = ready_q;

endmodule

// File: tb/tb_bank_wait_ctrl.sv
// Self-checking bench for bank_wait_ctrl: directed scenarios followed by
// random bus cycles, all checked against a register/timing model kept here.
module tb_bank_wait_ctrl;

    localparam int NW = 4;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic [19:0] ADDR = '0;
    logic        M_IO = 1'b1;
    logic        RD = 1'b1;
    logic        WR = 1'b1;
    logic [7:0]  DATA_IN = '0;
    logic [7:0]  DATA_OUT;
    logic        DATA_OE;
    logic        RDY_EXT = 1'b1;
    logic        win_hit;
    logic [4:0]  bank_sel;
    logic        READY;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [4:0] bank_m [NW];
    logic [7:0] ctrl_m;

    bank_wait_ctrl #(
        .NUM_WINDOWS(NW),
        .BANK_BITS(5),
        .WAIT_BITS(3),
        .IO_BASE(10'h030)
    ) dut (
        .clk(clk),
        .RESET(RESET),
        .ADDR(ADDR),
        .M_IO(M_IO),
        .RD(RD),
        .WR(WR),
        .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT),
        .DATA_OE(DATA_OE),
        .RDY_EXT(RDY_EXT),
        .win_hit(win_hit),
        .bank_sel(bank_sel),
        .READY(READY)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NW; i++) bank_m[i] = 5'(i);
        ctrl_m = 8'h00;
    endfunction

    function automatic bit in_window(input logic [19:0] a);
        return (int'(a) >= 'h80000) && (int'(a) < 'hC0000);
    endfunction

    function automatic int win_of(input logic [19:0] a);
        return (int'(a) - 'h80000) / ('h40000 / NW);
    endfunction

    function automatic bit in_block(input logic [19:0] a);
        int lo;
        lo = int'(a) % 1024;
        return (lo >= 'h30) && (lo < 'h38);
    endfunction

    function automatic int exp_wait(input logic mio, input logic [19:0] a);
        if (mio && in_window(a)) return int'(ctrl_m) % 8;
        if (!mio) return (int'(ctrl_m) / 16) % 8;
        return 0;
    endfunction

    function automatic logic [7:0] exp_read(input int p);
        if (p < NW) return {3'b000, bank_m[p]};
        if (p == 7) return ctrl_m;
        return 8'hFF;
    endfunction

    // One complete bus cycle: strobe held low for 'hold' clocks, then released.
    task automatic bus_cycle(input logic mio, input logic [19:0] a, input logic is_wr,
                             input logic [7:0] d, input int hold);
        int n;
        bit hit;
        bit blk;
        int p;
        ADDR = a; M_IO = mio; DATA_IN = d; RD = 1'b1; WR = 1'b1;
        tick();
        chk("idle_ready", READY, RDY_EXT);
        n   = exp_wait(mio, a);
        hit = mio && in_window(a);
        blk = !mio && in_block(a);
        p   = (int'(a) % 1024) - 'h30;
        if (is_wr) WR = 1'b0; else RD = 1'b0;
        #1;
        chk("win_hit", win_hit, hit);
        chk("bank_sel", bank_sel, hit ? bank_m[win_of(a)] : 5'd0);
        chk("data_oe", DATA_OE, blk && !is_wr);
        chk("data_out", DATA_OUT, (blk && !is_wr) ? exp_read(p) : 8'hFF);
        for (int j = 1; j <= hold; j++) begin
            tick();
            chk("ready_wait", READY, (j <= n) ? 1'b0 : RDY_EXT);
        end
        RD = 1'b1; WR = 1'b1;
        tick();
        chk("ready_release", READY, (hold <= n) ? 1'b1 : RDY_EXT);
        if (is_wr && blk) begin
            if (p < NW) bank_m[p] = d[4:0];
            else if (p == 7) ctrl_m = d;
        end
    endtask

    initial begin
        logic [19:0] a;
        int          r;
        model_reset();

        // Reset state
        tick();
        tick();
        chk("reset_ready", READY, 1'b1);
        RESET = 1'b0;
        tick();
        chk("post_reset_ready", READY, 1'b1);
        chk("post_reset_oe", DATA_OE, 1'b0);
        chk("post_reset_dout", DATA_OUT, 8'hFF);

        // Identity map and cleared CTRL
        for (int i = 0; i < 4; i++) bus_cycle(1'b0, 20'h00030 + 20'(i), 1'b0, 8'h00, 2);
        bus_cycle(1'b0, 20'h00037, 1'b0, 8'h00, 2);

        // Remap window 2, then access windows 2 and 1
        bus_cycle(1'b0, 20'h00032, 1'b1, 8'h1F, 2);
        bus_cycle(1'b1, 20'hA0000, 1'b0, 8'h00, 2);
        bus_cycle(1'b1, 20'h90000, 1'b0, 8'h00, 2);

        // Memory wait count of 3
        bus_cycle(1'b0, 20'h00037, 1'b1, 8'h03, 2);
        bus_cycle(1'b1, 20'h84000, 1'b0, 8'h00, 6);

        // I/O wait count of 2, and a non-window memory cycle with no wait
        bus_cycle(1'b0, 20'h00037, 1'b1, 8'h20, 2);
        bus_cycle(1'b0, 20'h00040, 1'b0, 8'h00, 4);
        bus_cycle(1'b1, 20'h00100, 1'b0, 8'h00, 3);

        // Unused port ignores writes and reads back FF
        bus_cycle(1'b0, 20'h00035, 1'b1, 8'hAA, 3);
        bus_cycle(1'b0, 20'h00035, 1'b0, 8'h00, 3);

        // External ready held low through DONE
        bus_cycle(1'b0, 20'h00037, 1'b1, 8'h01, 3);
        ADDR = 20'h84000; M_IO = 1'b1; RD = 1'b1; WR = 1'b1;
        tick();
        RD = 1'b0;
        tick();
        chk("rdyext_wait", READY, 1'b0);
        RDY_EXT = 1'b0;
        tick();
        chk("rdyext_done0", READY, 1'b0);
        tick();
        chk("rdyext_done1", READY, 1'b0);
        RDY_EXT = 1'b1;
        tick();
        chk("rdyext_back", READY, 1'b1);
        RD = 1'b1;
        tick();
        chk("rdyext_release", READY, 1'b1);

        // Reset in the middle of a wait with two clocks left
        bus_cycle(1'b0, 20'h00037, 1'b1, 8'h04, 2);
        ADDR = 20'h84000; M_IO = 1'b1; RD = 1'b1; WR = 1'b1;
        tick();
        RD = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("pre_reset_wait", READY, 1'b0);
        end
        RESET = 1'b1;
        tick();
        chk("mid_wait_reset", READY, 1'b1);
        RESET = 1'b0;
        model_reset();
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("held_rd_no_wait", READY, 1'b1);
        end
        RD = 1'b1;
        tick();
        bus_cycle(1'b0, 20'h00037, 1'b0, 8'h00, 2);
        bus_cycle(1'b0, 20'h00032, 1'b0, 8'h00, 2);

        // Random bus traffic
        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 5));
            case (r)
                0: begin
                    a = {10'($urandom), 10'h030 + 10'($urandom_range(0, 7))};
                    bus_cycle(1'b0, a, 1'b1, 8'($urandom), int'($urandom_range(1, 10)));
                end
                1: begin
                    a = {10'($urandom), 10'h030 + 10'($urandom_range(0, 7))};
                    bus_cycle(1'b0, a, 1'b0, 8'h00, int'($urandom_range(1, 10)));
                end
                2: begin
                    a = 20'($urandom);
                    bus_cycle(1'b0, a, 1'($urandom), 8'($urandom), int'($urandom_range(1, 10)));
                end
                default: begin
                    if ($urandom_range(0, 1) == 1) a = 20'h80000 + 20'($urandom_range(0, 'h3FFFF));
                    else a = 20'($urandom);
                    bus_cycle(1'b1, a, 1'($urandom), 8'($urandom), int'($urandom_range(1, 10)));
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
